// File: rtl/vector_dispatch.sv
// Issue controller for the vector lane array: accepts one instruction, starts the lanes,
// streams write data, assembles read data and returns a single response.
module vector_dispatch #(
  parameter int vlen_p     = 8,
  parameter int vdw_p      = 8,
  parameter int els_p      = 8,
  parameter int lanes_p    = 4,
  parameter int op_width_p = 4,
  parameter int timeout_p  = 64,
  localparam int v_addr_width_lp = $clog2(els_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [op_width_p-1:0]        op_i,
  input  logic [v_addr_width_lp-1:0]   vd_i,
  input  logic [v_addr_width_lp-1:0]   vs1_i,
  input  logic [v_addr_width_lp-1:0]   vs2_i,
  input  logic [vdw_p-1:0]             scalar_i,
  input  logic [vlen_p*vdw_p-1:0]      w_vec_i,
  output logic                         v_o,
  input  logic                         yumi_i,
  output logic [vlen_p*vdw_p-1:0]      r_vec_o,
  output logic                         error_o,
  output logic                         start_o,
  output logic [op_width_p-1:0]        op_o,
  output logic [vdw_p-1:0]             scalar_o,
  output logic [v_addr_width_lp-1:0]   vd_o,
  output logic [v_addr_width_lp-1:0]   vs1_o,
  output logic [v_addr_width_lp-1:0]   vs2_o,
  output logic [lanes_p*vdw_p-1:0]     lane_w_data_o,
  input  logic [lanes_p-1:0]           lane_v_i,
  input  logic [lanes_p*vdw_p-1:0]     lane_r_data_i,
  input  logic [lanes_p-1:0]           lane_done_i
);

  localparam int beats_lp      = vlen_p / lanes_p;
  localparam int rb_width_lp   = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int beat_width_lp = $clog2(beats_lp + 1);
  localparam int tmo_width_lp  = (timeout_p > 1) ? $clog2(timeout_p) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                        state_r, state_n;
  logic [vlen_p*vdw_p-1:0]       w_vec_r;
  logic [vlen_p*vdw_p-1:0]       r_vec_r;
  logic [lanes_p-1:0]            done_mask_r;
  logic [beat_width_lp-1:0]      beat_r;
  logic [rb_width_lp-1:0]        rb_r [lanes_p];
  logic [tmo_width_lp-1:0]       tmo_r;
  logic                          error_r;
  logic [op_width_p-1:0]         op_r;
  logic [vdw_p-1:0]              scalar_r;
  logic [v_addr_width_lp-1:0]    vd_r, vs1_r, vs2_r;

  logic accept, all_done, timed_out, stream_active;

  assign accept        = v_i & (state_r == IDLE);
  assign all_done      = &(done_mask_r | lane_done_i);
  assign timed_out     = (tmo_r == tmo_width_lp'(timeout_p - 1));
  assign stream_active = (state_r == ISSUE) ||
                         ((state_r == WAIT) && (beat_r < beat_width_lp'(beats_lp)));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:    if (v_i) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (all_done || timed_out) state_n = RESP;
      RESP:    if (yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Beat k of the latched vector is presented in the k-th cycle counted from ISSUE.
  always_comb begin
    lane_w_data_o = '0;
    if (stream_active) begin
      for (int l = 0; l < lanes_p; l++) begin
        lane_w_data_o[l*vdw_p +: vdw_p] = w_vec_r[(int'(beat_r)*lanes_p + l)*vdw_p +: vdw_p];
      end
    end
  end

  // NOTE: the read buffer drives a port with a defined reset value, so it is reset like any other flop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      w_vec_r     <= '0;
      r_vec_r     <= '0;
      done_mask_r <= '0;
      beat_r      <= '0;
      tmo_r       <= '0;
      error_r     <= 1'b0;
      op_r        <= '0;
      scalar_r    <= '0;
      vd_r        <= '0;
      vs1_r       <= '0;
      vs2_r       <= '0;
      for (int l = 0; l < lanes_p; l++) rb_r[l] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_r <= state_n;

      if (accept) begin
        op_r        <= op_i;
        scalar_r    <= scalar_i;
        vd_r        <= vd_i;
        vs1_r       <= vs1_i;
        vs2_r       <= vs2_i;
        w_vec_r     <= w_vec_i;
        r_vec_r     <= '0;
        done_mask_r <= '0;
        error_r     <= 1'b0;
        beat_r      <= '0;
        for (int l = 0; l < lanes_p; l++) rb_r[l] <= '0;
      end

      if (state_r == ISSUE) tmo_r <= '0;

      if (stream_active) beat_r <= beat_r + 1'b1;

      if (state_r == WAIT) begin
        tmo_r       <= tmo_r + 1'b1;
        done_mask_r <= done_mask_r | lane_done_i;
        if (timed_out && !all_done) error_r <= 1'b1;
        for (int l = 0; l < lanes_p; l++) begin
          if (lane_v_i[l]) begin
            r_vec_r[(int'(rb_r[l])*lanes_p + l)*vdw_p +: vdw_p] <= lane_r_data_i[l*vdw_p +: vdw_p];
            if (rb_r[l] != rb_width_lp'(beats_lp - 1)) rb_r[l] <= rb_r[l] + 1'b1;
          end
        end
      end
    end
  end

  assign ready_o  = (state_r == IDLE);
  assign start_o  = (state_r == ISSUE);
  assign v_o      = (state_r == RESP);
  assign r_vec_o  = r_vec_r;
  assign error_o  = error_r;
  assign op_o     = op_r;
  assign scalar_o = scalar_r;
  assign vd_o     = vd_r;
  assign vs1_o    = vs1_r;
  assign vs2_o    = vs2_r;

endmodule

// File: tb/tb_vector_dispatch.sv
// Self-checking bench for vector_dispatch: randomized instructions and lane behaviour
// compared against a cycle-count / element-array model of the dispatcher.
module tb_vector_dispatch;

  localparam int VLEN  = 8;
  localparam int VDW   = 8;
  localparam int ELS   = 8;
  localparam int LANES = 4;
  localparam int OPW   = 4;
  localparam int TMO   = 64;
  localparam int B     = VLEN / LANES;
  localparam int AW    = $clog2(ELS);

  logic                   clk_i = 1'b0;
  logic                   reset_n_i = 1'b0;
  logic                   v_i = 1'b0;
  logic                   ready_o;
  logic [OPW-1:0]         op_i = '0;
  logic [AW-1:0]          vd_i = '0, vs1_i = '0, vs2_i = '0;
  logic [VDW-1:0]         scalar_i = '0;
  logic [VLEN*VDW-1:0]    w_vec_i = '0;
  logic                   v_o;
  logic                   yumi_i = 1'b0;
  logic [VLEN*VDW-1:0]    r_vec_o;
  logic                   error_o;
  logic                   start_o;
  logic [OPW-1:0]         op_o;
  logic [VDW-1:0]         scalar_o;
  logic [AW-1:0]          vd_o, vs1_o, vs2_o;
  logic [LANES*VDW-1:0]   lane_w_data_o;
  logic [LANES-1:0]       lane_v_i = '0;
  logic [LANES*VDW-1:0]   lane_r_data_i = '0;
  logic [LANES-1:0]       lane_done_i = '0;

  int total = 0;
  int bad   = 0;

  vector_dispatch #(
    .vlen_p(VLEN), .vdw_p(VDW), .els_p(ELS), .lanes_p(LANES),
    .op_width_p(OPW), .timeout_p(TMO)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
    .op_i(op_i), .vd_i(vd_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .scalar_i(scalar_i),
    .w_vec_i(w_vec_i), .v_o(v_o), .yumi_i(yumi_i), .r_vec_o(r_vec_o),
    .error_o(error_o), .start_o(start_o), .op_o(op_o), .scalar_o(scalar_o),
    .vd_o(vd_o), .vs1_o(vs1_o), .vs2_o(vs2_o), .lane_w_data_o(lane_w_data_o),
    .lane_v_i(lane_v_i), .lane_r_data_i(lane_r_data_i), .lane_done_i(lane_done_i)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [VLEN*VDW-1:0] rand_vec();
    logic [VLEN*VDW-1:0] v;
    for (int e = 0; e < VLEN; e++) v[e*VDW +: VDW] = VDW'($urandom);
    return v;
  endfunction

  // One complete instruction. done_t[l] is the cycle (relative to ISSUE = 0) of lane l's
  // done pulse, or -1 for never.
  task automatic run_op(input logic [OPW-1:0] op, input logic [VDW-1:0] sc,
                        input logic [AW-1:0] vd, input logic [AW-1:0] vs1, input logic [AW-1:0] vs2,
                        input logic [VLEN*VDW-1:0] wv, input int done_t [LANES],
                        input bit pulse_issue, input int hold);
    logic [VDW-1:0]       rd [B][LANES];
    logic [VLEN*VDW-1:0]  exp_r;
    logic [LANES*VDW-1:0] exp_w;
    int  maxd, exp_resp, seen, t;
    bit  never, exp_err, is_read;

    is_read = (op == 4'b1000);
    exp_r = '0;
    for (int b = 0; b < B; b++)
      for (int l = 0; l < LANES; l++) begin
        rd[b][l] = VDW'($urandom);
        exp_r[(b*LANES + l)*VDW +: VDW] = rd[b][l];
      end
    maxd = 0; never = 0;
    for (int l = 0; l < LANES; l++) begin
      if (done_t[l] < 0) never = 1;
      else if (done_t[l] > maxd) maxd = done_t[l];
    end
    if (!never && maxd < TMO) begin exp_resp = maxd + 1; exp_err = 0; end
    else begin exp_resp = TMO + 1; exp_err = 1; end

    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL accept_ready: got %b want 1", ready_o); end
    v_i = 1'b1; op_i = op; scalar_i = sc; vd_i = vd; vs1_i = vs1; vs2_i = vs2; w_vec_i = wv;
    tick();
    v_i = 1'b0; op_i = OPW'($urandom); scalar_i = VDW'($urandom); w_vec_i = rand_vec();

    seen = -1;
    t = 0;
    while (t <= TMO + 4) begin
      lane_done_i = '0; lane_v_i = '0; lane_r_data_i = '0;
      for (int l = 0; l < LANES; l++) if (done_t[l] == t) lane_done_i[l] = 1'b1;
      if (pulse_issue && t == 0) lane_done_i = '1;
      if (is_read && t >= 1 && t <= B)
        for (int l = 0; l < LANES; l++) begin
          lane_v_i[l] = 1'b1;
          lane_r_data_i[l*VDW +: VDW] = rd[t-1][l];
        end
      exp_w = '0;
      if (t < B)
        for (int l = 0; l < LANES; l++) exp_w[l*VDW +: VDW] = wv[(t*LANES + l)*VDW +: VDW];

      total++;
      if (start_o !== (t == 0)) begin bad++; $display("FAIL start t=%0d: got %b want %b", t, start_o, t == 0); end
      total++;
      if (lane_w_data_o !== exp_w) begin bad++; $display("FAIL w_data t=%0d: got %h want %h", t, lane_w_data_o, exp_w); end
      total++;
      if (v_o !== (t == exp_resp)) begin bad++; $display("FAIL v_o t=%0d: got %b want %b", t, v_o, t == exp_resp); end
      if (t == 0) begin
        total++;
        if ({op_o, scalar_o, vd_o, vs1_o, vs2_o} !== {op, sc, vd, vs1, vs2}) begin
          bad++; $display("FAIL fields_issue: got %h want %h", {op_o, scalar_o, vd_o, vs1_o, vs2_o}, {op, sc, vd, vs1, vs2});
        end
      end
      if (v_o === 1'b1) begin seen = t; break; end
      total++;
      if (ready_o !== 1'b0) begin bad++; $display("FAIL busy_ready t=%0d: got %b want 0", t, ready_o); end
      tick();
      t++;
    end
    lane_done_i = '0; lane_v_i = '0; lane_r_data_i = '0;

    total++;
    if (seen != exp_resp) begin bad++; $display("FAIL resp_time: got %0d want %0d", seen, exp_resp); end

    for (int h = 0; h <= hold; h++) begin
      total++;
      if (v_o !== 1'b1) begin bad++; $display("FAIL resp_hold: got %b want 1", v_o); end
      total++;
      if (error_o !== exp_err) begin bad++; $display("FAIL error: got %b want %b", error_o, exp_err); end
      total++;
      if ({op_o, scalar_o, vd_o, vs1_o, vs2_o} !== {op, sc, vd, vs1, vs2}) begin
        bad++; $display("FAIL fields_resp: got %h want %h", {op_o, scalar_o, vd_o, vs1_o, vs2_o}, {op, sc, vd, vs1, vs2});
      end
      if (is_read) begin
        total++;
        if (r_vec_o !== exp_r) begin bad++; $display("FAIL r_vec: got %h want %h", r_vec_o, exp_r); end
      end
      if (h < hold) tick();
    end

    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    total++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      bad++; $display("FAIL after_yumi: got ready=%b v=%b want ready=1 v=0", ready_o, v_o);
    end
    total++;
    if (error_o !== exp_err) begin bad++; $display("FAIL error_held: got %b want %b", error_o, exp_err); end
    if (is_read) begin
      total++;
      if (r_vec_o !== exp_r) begin bad++; $display("FAIL r_vec_held: got %h want %h", r_vec_o, exp_r); end
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || start_o !== 1'b0 || error_o !== 1'b0) begin
      bad++; $display("FAIL %s_ctrl: got ready=%b v=%b start=%b err=%b want 1 0 0 0", tag, ready_o, v_o, start_o, error_o);
    end
    total++;
    if (r_vec_o !== '0 || lane_w_data_o !== '0) begin
      bad++; $display("FAIL %s_data: got r=%h w=%h want 0", tag, r_vec_o, lane_w_data_o);
    end
    total++;
    if ({op_o, scalar_o, vd_o, vs1_o, vs2_o} !== '0) begin
      bad++; $display("FAIL %s_fields: got %h want 0", tag, {op_o, scalar_o, vd_o, vs1_o, vs2_o});
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) tick();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();
    check_reset_values("post_reset");
  endtask

  task automatic test_alu();
    int d [LANES];
    for (int l = 0; l < LANES; l++) d[l] = B + 3;
    run_op(4'b0000, 8'h05, 3'd1, 3'd2, 3'd3, rand_vec(), d, 0, 0);
    run_op(4'b0100, 8'hA5, 3'd7, 3'd0, 3'd6, rand_vec(), d, 0, 1);
  endtask

  task automatic test_read();
    int d [LANES];
    for (int l = 0; l < LANES; l++) d[l] = B + 1;
    run_op(4'b1000, 8'h00, 3'd0, 3'd4, 3'd0, rand_vec(), d, 0, 2);
  endtask

  task automatic test_write();
    int d [LANES];
    logic [VLEN*VDW-1:0] wv;
    for (int e = 0; e < VLEN; e++) wv[e*VDW +: VDW] = VDW'(8'h20 + e);
    for (int l = 0; l < LANES; l++) d[l] = B + 3;
    run_op(4'b1001, 8'h00, 3'd5, 3'd0, 3'd0, wv, d, 0, 0);
  endtask

  task automatic test_staggered();
    int d [LANES];
    d[0] = 3; d[1] = 3; d[2] = 7; d[3] = 7;
    lane_done_i = '1;
    tick();
    lane_done_i = '0;
    run_op(4'b0011, 8'h11, 3'd2, 3'd3, 3'd4, rand_vec(), d, 1, 0);
  endtask

  task automatic test_timeout();
    int d [LANES];
    for (int l = 0; l < LANES - 1; l++) d[l] = B + 3;
    d[LANES-1] = -1;
    run_op(4'b0001, 8'h22, 3'd1, 3'd1, 3'd1, rand_vec(), d, 0, 1);
    for (int l = 0; l < LANES; l++) d[l] = B + 3;
    run_op(4'b0010, 8'h33, 3'd6, 3'd5, 3'd4, rand_vec(), d, 0, 0);
  endtask

  task automatic test_back_to_back();
    int d [LANES];
    for (int n = 0; n < 3; n++) begin
      for (int l = 0; l < LANES; l++) d[l] = (n == 1) ? B + 1 : B + 3;
      run_op((n == 1) ? 4'b1000 : 4'b1001, VDW'($urandom), AW'($urandom), AW'($urandom),
             AW'($urandom), rand_vec(), d, 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    logic [VDW-1:0] beat0 [LANES];
    logic [VLEN*VDW-1:0] exp_r;
    int d [LANES];
    exp_r = '0;
    v_i = 1'b1; op_i = 4'b1000; scalar_i = 8'h77; vd_i = 3'd3; vs1_i = 3'd3; vs2_i = 3'd3;
    tick();
    v_i = 1'b0;
    tick();
    for (int l = 0; l < LANES; l++) begin
      beat0[l] = VDW'($urandom_range(1, 255));
      lane_v_i[l] = 1'b1;
      lane_r_data_i[l*VDW +: VDW] = beat0[l];
      exp_r[l*VDW +: VDW] = beat0[l];
    end
    tick();
    lane_v_i = '0; lane_r_data_i = '0;
    total++;
    if (r_vec_o !== exp_r) begin bad++; $display("FAIL partial_read: got %h want %h", r_vec_o, exp_r); end
    reset_n_i = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();
    for (int l = 0; l < LANES; l++) d[l] = B + 3;
    run_op(4'b0110, 8'h44, 3'd2, 3'd2, 3'd2, rand_vec(), d, 0, 0);
  endtask

  task automatic test_random();
    int d [LANES];
    logic [OPW-1:0] op;
    int base;
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 2))
        0:       op = 4'b1000;
        1:       op = 4'b1001;
        default: op = OPW'($urandom_range(0, 7));
      endcase
      base = (op == 4'b1000) ? B + 1 : B + 3;
      for (int l = 0; l < LANES; l++) d[l] = base + int'($urandom_range(0, 3));
      run_op(op, VDW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
             rand_vec(), d, $urandom_range(0, 1) == 1, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_read();
    test_write();
    test_staggered();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
